// File: rtl/srl_nxm_dly_if.sv
// Bus bundle for the programmable SRL delay line: control/data towards the core,
// delayed word plus fill status back to the controller.
interface srl_nxm_dly_if #(
    parameter int Width    = 8,
    parameter int MaxDepth = 16
);
    localparam int AW = $clog2(MaxDepth);
    localparam int CW = $clog2(MaxDepth + 1);

    logic             ce;
    logic             clr;
    logic [AW-1:0]    dly;
    logic [Width-1:0] d;
    logic [Width-1:0] q;
    logic             valid;
    logic [CW-1:0]    fill;
    logic             sat;

    modport master (
        output ce, clr, dly, d,
        input  q, valid, fill, sat
    );

    modport slave (
        input  ce, clr, dly, d,
        output q, valid, fill, sat
    );
endinterface

// File: rtl/srl_nxm_dly.sv
// Runtime-programmable delay line: delays a word by dly+1 enabled cycles using
// reset-free shift storage, and qualifies the tap with a saturating fill count.
module srl_nxm_dly #(
    parameter int Width    = 8,
    parameter int MaxDepth = 16,
    parameter int OutReg   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    srl_nxm_dly_if.slave bus
);
    localparam int AW = $clog2(MaxDepth);
    localparam int CW = $clog2(MaxDepth + 1);

    logic [Width-1:0] sr [MaxDepth];
    logic [AW-1:0]    tapIdx;
    logic [CW-1:0]    fillCnt;
    logic [Width-1:0] rawTap;
    logic             validComb;
    logic [Width-1:0] qComb;

    // Storage carries no reset so the tools can map it onto SRL primitives.
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            sr[0] <= bus.d;
            for (int k = 1; k < MaxDepth; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    always_comb begin
        tapIdx = bus.dly;
        if (int'(bus.dly) > MaxDepth - 1) begin
            tapIdx = AW'(MaxDepth - 1);
        end
    end

    // A flush wins over the enable, so a word shifted in alongside clr is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fillCnt <= '0;
        end else if (bus.clr) begin
            fillCnt <= '0;
        end else if (bus.ce && (fillCnt != CW'(MaxDepth))) begin
            fillCnt <= fillCnt + CW'(1);
        end
    end

    assign rawTap    = sr[tapIdx];
    assign validComb = (fillCnt > CW'(tapIdx));
    assign qComb     = validComb ? rawTap : '0;

    assign bus.fill = fillCnt;
    assign bus.sat  = (fillCnt == CW'(MaxDepth));

    generate
        if (OutReg != 0) begin : gOutReg
            logic [Width-1:0] qReg;
            logic             validReg;

            // Output stage samples every clock, independent of ce, so dly changes still propagate.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qReg     <= '0;
                    validReg <= 1'b0;
                end else begin
                    qReg     <= qComb;
                    validReg <= validComb;
                end
            end

            assign bus.q     = qReg;
            assign bus.valid = validReg;
        end else begin : gOutComb
            assign bus.q     = qComb;
            assign bus.valid = validComb;
        end
    endgenerate
endmodule

// File: tb/tb_srl_nxm_dly.sv
// Directed bench for srl_nxm_dly: a combinational-output 16-deep instance and a
// registered-output 12-deep instance that also exercises delay clamping.
module tb_srl_nxm_dly;
    logic clk;
    logic rst_n;
    int   totalChecks = 0;
    int   badChecks   = 0;

    srl_nxm_dly_if #(.Width(8), .MaxDepth(16)) bus0 ();
    srl_nxm_dly_if #(.Width(8), .MaxDepth(12)) bus1 ();

    srl_nxm_dly #(.Width(8), .MaxDepth(16), .OutReg(0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    srl_nxm_dly #(.Width(8), .MaxDepth(12), .OutReg(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic clr, input logic [7:0] d);
        bus0.ce  = ce;
        bus0.clr = clr;
        bus0.d   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusReg(input logic ce, input logic clr, input logic [7:0] d);
        bus1.ce  = ce;
        bus1.clr = clr;
        bus1.d   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        bus0.ce  = 1'b0;
        bus0.clr = 1'b0;
        bus0.dly = 4'd3;
        bus0.d   = 8'd0;
        bus1.ce  = 1'b0;
        bus1.clr = 1'b0;
        bus1.dly = 4'd0;
        bus1.d   = 8'd0;
        #3 rst_n = 1'b0;
        #4;
        checkOutput("rst q", 32'(bus0.q), 0);
        checkOutput("rst valid", 32'(bus0.valid), 0);
        checkOutput("rst fill", 32'(bus0.fill), 0);
        checkOutput("rst sat", 32'(bus0.sat), 0);
        checkOutput("rst q reg", 32'(bus1.q), 0);
        checkOutput("rst valid reg", 32'(bus1.valid), 0);
        #1 rst_n = 1'b1;

        // Delay 4 with an incrementing stream
        for (int n = 1; n <= 6; n++) begin
            applyStimulus(1'b1, 1'b0, 8'(n));
            checkOutput("t1 valid", 32'(bus0.valid), (n >= 4) ? 1 : 0);
            checkOutput("t1 q", 32'(bus0.q), (n >= 4) ? n - 3 : 0);
            checkOutput("t1 fill", 32'(bus0.fill), n);
        end

        // Maximum delay and saturation
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("t2 clr fill", 32'(bus0.fill), 0);
        bus0.dly = 4'd15;
        for (int n = 1; n <= 18; n++) begin
            applyStimulus(1'b1, 1'b0, 8'(100 + n));
            checkOutput("t2 valid", 32'(bus0.valid), (n >= 16) ? 1 : 0);
            checkOutput("t2 q", 32'(bus0.q), (n >= 16) ? 100 + n - 15 : 0);
            checkOutput("t2 fill", 32'(bus0.fill), (n >= 16) ? 16 : n);
            checkOutput("t2 sat", 32'(bus0.sat), (n >= 16) ? 1 : 0);
        end

        // Live dly changes, then a flush and refill
        bus0.dly = 4'd7;
        #1;
        checkOutput("t4 dly7 q", 32'(bus0.q), 111);
        checkOutput("t4 dly7 valid", 32'(bus0.valid), 1);
        bus0.dly = 4'd2;
        #1;
        checkOutput("t4 dly2 q", 32'(bus0.q), 116);
        checkOutput("t4 dly2 valid", 32'(bus0.valid), 1);
        applyStimulus(1'b1, 1'b1, 8'd200);
        checkOutput("t4 clr valid", 32'(bus0.valid), 0);
        checkOutput("t4 clr q", 32'(bus0.q), 0);
        checkOutput("t4 clr fill", 32'(bus0.fill), 0);
        for (int n = 1; n <= 3; n++) begin
            applyStimulus(1'b1, 1'b0, 8'(200 + n));
            checkOutput("t4 refill valid", 32'(bus0.valid), (n == 3) ? 1 : 0);
            checkOutput("t4 refill q", 32'(bus0.q), (n == 3) ? 201 : 0);
            checkOutput("t4 refill fill", 32'(bus0.fill), n);
        end

        // Alternating enable with delay 2
        bus0.dly = 4'd1;
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("t3 clr fill", 32'(bus0.fill), 0);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = i / 2 + 1;
            applyStimulus((i % 2) == 0, 1'b0, 8'(50 + i));
            checkOutput("t3 fill", 32'(bus0.fill), k);
            checkOutput("t3 valid", 32'(bus0.valid), (k > 1) ? 1 : 0);
            checkOutput("t3 q", 32'(bus0.q), (k > 1) ? 50 + 2 * (k - 2) : 0);
        end

        // Asynchronous reset between edges, then recovery
        bus0.dly = 4'd3;
        #1;
        checkOutput("t5 pre valid", 32'(bus0.valid), 1);
        checkOutput("t5 pre q", 32'(bus0.q), 50);
        rst_n = 1'b0;
        #2;
        checkOutput("t5 rst q", 32'(bus0.q), 0);
        checkOutput("t5 rst valid", 32'(bus0.valid), 0);
        checkOutput("t5 rst fill", 32'(bus0.fill), 0);
        checkOutput("t5 rst sat", 32'(bus0.sat), 0);
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(1'b1, 1'b0, 8'(60 + n));
            checkOutput("t5 valid", 32'(bus0.valid), (n >= 4) ? 1 : 0);
            checkOutput("t5 q", 32'(bus0.q), (n >= 4) ? 61 : 0);
        end
        bus0.ce = 1'b0;

        // Registered output, single-cycle delay
        for (int n = 1; n <= 3; n++) begin
            applyStimulusReg(1'b1, 1'b0, 8'(10 + n));
            checkOutput("t6 valid", 32'(bus1.valid), (n >= 2) ? 1 : 0);
            checkOutput("t6 q", 32'(bus1.q), (n >= 2) ? 10 + n - 1 : 0);
        end

        // Out-of-range dly clamps to the last stage
        applyStimulusReg(1'b0, 1'b1, 8'd0);
        checkOutput("t6 clr fill", 32'(bus1.fill), 0);
        bus1.dly = 4'd15;
        for (int n = 1; n <= 13; n++) begin
            applyStimulusReg(1'b1, 1'b0, 8'(20 + n));
            checkOutput("t6 clamp valid", 32'(bus1.valid), (n >= 13) ? 1 : 0);
            checkOutput("t6 clamp q", 32'(bus1.q), (n >= 13) ? 20 + n - 12 : 0);
            checkOutput("t6 clamp fill", 32'(bus1.fill), (n >= 12) ? 12 : n);
            checkOutput("t6 clamp sat", 32'(bus1.sat), (n >= 12) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
